mips_fetch_unit: RTL and testbench

Instruction fetch front end for the MIPS pipeline. Owns the PC, issues word reads to instruction memory, and buffers returned words with their PCs in an in-order ring. It presents them to the decoder through a valid/ready handshake as `inst_out` (decoder `ReadInstruction`) and `inst_pc` (decoder `ReadAddress`). Jump and branch targets resolved downstream arrive on the redirect port, which flushes wrong-path instructions.

---
 rtl/mips_fetch_pkg.sv | 15 +
 rtl/fetch_ring.sv | 77 +++++++
 rtl/mips_fetch_unit.sv | 85 ++++++++
 tb/tb_mips_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch front end.
package mips_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef struct packed {
      logic        alloc;
      logic        filled;
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order instruction ring: an entry is allocated when a request is accepted,
// filled when its word returns and freed when the decoder consumes it.
module fetch_ring
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         alloc_en,
   input  logic [31:0]  alloc_pc,
   input  logic         fill_en,
   input  logic [31:0]  fill_inst,
   input  logic         pop_en,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic [CW-1:0] unfilled
);

   fetch_entry_t  entries [DEPTH];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] alloc_ptr;
   logic [PW-1:0] fill_ptr;
   logic [CW-1:0] count_q;

   // Alloc, fill and pop always target distinct slots, so all three may land in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         head_ptr  <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         count_q   <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         head_ptr  <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         count_q   <= '0;
      end else begin
         if (alloc_en) begin
            entries[alloc_ptr] <= '{alloc: 1'b1, filled: 1'b0, pc: alloc_pc, inst: INST_NOP};
            alloc_ptr          <= alloc_ptr + PW'(1);
         end
         if (fill_en) begin
            entries[fill_ptr].filled <= 1'b1;
            entries[fill_ptr].inst   <= fill_inst;
            fill_ptr                 <= fill_ptr + PW'(1);
         end
         if (pop_en) begin
            entries[head_ptr] <= '0;
            head_ptr          <= head_ptr + PW'(1);
         end
         count_q <= count_q + CW'(alloc_en) - CW'(pop_en);
      end
   end

   always_comb begin
      unfilled = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].alloc && !entries[i].filled) begin
            unfilled = unfilled + CW'(1);
         end
      end
   end

   assign head  = entries[head_ptr];
   assign count = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch front end: owns the PC, issues word reads, and discards responses that
// belong to requests made before a redirect.
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] drop_redirect;
   logic [CW-1:0] ring_count;
   logic [CW-1:0] ring_unfilled;
   fetch_entry_t  head;
   logic          accept;
   logic          fill;
   logic          pop;

   assign imem_req_valid = !rst && (ring_count < CW'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign fill           = imem_resp_valid && !redirect_valid && (drop_cnt == '0);

   assign inst_valid = head.alloc && head.filled && !redirect_valid;
   assign inst_out   = head.inst;
   assign inst_pc    = head.pc;
   assign pop        = inst_valid && inst_ready;

   // Every word still owed to the flushed ring must be thrown away, except one arriving right now.
   assign drop_redirect = drop_cnt + ring_unfilled - CW'(imem_resp_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc & 32'hFFFF_FFFC;
      end else if (accept) begin
         pc <= pc + PC_STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         drop_cnt <= drop_redirect;
      end else if (imem_resp_valid && (drop_cnt != '0)) begin
         drop_cnt <= drop_cnt - CW'(1);
      end
   end

   fetch_ring #(
      .DEPTH(DEPTH)
   ) u_ring (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .alloc_en (accept),
      .alloc_pc (pc),
      .fill_en  (fill),
      .fill_inst(imem_resp_data),
      .pop_en   (pop),
      .head     (head),
      .count    (ring_count),
      .unfilled (ring_unfilled)
   );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with an in-order, fixed-latency memory model.
module tb_mips_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend_q[$];
   int    cur_cycle   = 0;
   int    mem_lat     = 1;
   int    vectors     = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   mips_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc)
   );

   // Memory contents: an addiu-like word tagged with the word index.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h2400_0000 | {2'b00, a[31:2]};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic rv, input logic [31:0] rpc, input logic ir, input logic qr);
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = ir;
      imem_req_ready = qr;
      #1;
   endtask

   // Record this cycle's accepted request, cross the rising edge, then drive any due response.
   task automatic next_cycle();
      if (imem_req_valid && imem_req_ready) begin
         pend_q.push_back('{addr: imem_req_addr, due: cur_cycle + mem_lat});
      end
      @(posedge clk);
      @(negedge clk);
      cur_cycle++;
      if (pend_q.size() > 0 && pend_q[0].due <= cur_cycle) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      inst_ready      = 1'b0;
      imem_req_ready  = 1'b0;
      pend_q.delete();
      #1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int exp_pc;
      int popped;
      int accepted;

      // Reset values
      @(negedge clk);
      #1;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("reset_req_valid", 32'(imem_req_valid), 32'd0);
      check_output("reset_inst_valid", 32'(inst_valid), 32'd0);
      check_output("reset_inst_out", inst_out, 32'h0);
      check_output("reset_inst_pc", inst_pc, 32'h0);

      // Streaming with 1-cycle memory
      do_reset();
      mem_lat = 1;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("stream_c0_req_valid", 32'(imem_req_valid), 32'd1);
      check_output("stream_c0_addr", imem_req_addr, 32'h3000);
      next_cycle();
      check_output("stream_c1_addr", imem_req_addr, 32'h3004);
      check_output("stream_c1_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("stream_c2_addr", imem_req_addr, 32'h3008);
      check_output("stream_c2_inst_valid", 32'(inst_valid), 32'd1);
      check_output("stream_c2_inst_pc", inst_pc, 32'h3000);
      check_output("stream_c2_inst_out", inst_out, 32'h2400_0C00);
      next_cycle();
      check_output("stream_c3_inst_pc", inst_pc, 32'h3004);
      check_output("stream_c3_inst_out", inst_out, 32'h2400_0C01);
      next_cycle();
      check_output("stream_c4_inst_pc", inst_pc, 32'h3008);

      // Back-pressure fills the ring, then drains in order
      do_reset();
      mem_lat = 1;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
      check_output("bp_c0_addr", imem_req_addr, 32'h3000);
      next_cycle();
      check_output("bp_c1_addr", imem_req_addr, 32'h3004);
      next_cycle();
      check_output("bp_c2_addr", imem_req_addr, 32'h3008);
      next_cycle();
      check_output("bp_c3_addr", imem_req_addr, 32'h300C);
      check_output("bp_c3_req_valid", 32'(imem_req_valid), 32'd1);
      next_cycle();
      check_output("bp_c4_req_valid", 32'(imem_req_valid), 32'd0);
      next_cycle();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("bp_c5_req_valid", 32'(imem_req_valid), 32'd0);
      check_output("bp_c5_inst_pc", inst_pc, 32'h3000);
      next_cycle();
      check_output("bp_c6_inst_pc", inst_pc, 32'h3004);
      check_output("bp_c6_req_valid", 32'(imem_req_valid), 32'd1);
      check_output("bp_c6_addr", imem_req_addr, 32'h3010);
      next_cycle();
      check_output("bp_c7_inst_pc", inst_pc, 32'h3008);
      next_cycle();
      check_output("bp_c8_inst_pc", inst_pc, 32'h300C);
      next_cycle();
      check_output("bp_c9_inst_pc", inst_pc, 32'h3010);
      check_output("bp_c9_inst_out", inst_out, 32'h2400_0C04);

      // Redirect with two words in flight on 3-cycle memory
      do_reset();
      mem_lat = 3;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("rd_c0_addr", imem_req_addr, 32'h3000);
      next_cycle();
      check_output("rd_c1_addr", imem_req_addr, 32'h3004);
      next_cycle();
      apply_stimulus(1'b1, 32'h3402, 1'b1, 1'b1);
      check_output("rd_c2_req_valid", 32'(imem_req_valid), 32'd0);
      check_output("rd_c2_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("rd_c3_addr", imem_req_addr, 32'h3400);
      check_output("rd_c3_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("rd_c4_addr", imem_req_addr, 32'h3404);
      check_output("rd_c4_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("rd_c5_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("rd_c6_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("rd_c7_inst_valid", 32'(inst_valid), 32'd1);
      check_output("rd_c7_inst_pc", inst_pc, 32'h3400);
      check_output("rd_c7_inst_out", inst_out, 32'h2400_0D00);
      check_output("rd_c7_req_valid", 32'(imem_req_valid), 32'd0);

      // Redirect coinciding with a response and a pop attempt
      do_reset();
      mem_lat = 1;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      next_cycle();
      next_cycle();
      apply_stimulus(1'b1, 32'h5000, 1'b1, 1'b1);
      check_output("rc_c2_inst_valid", 32'(inst_valid), 32'd0);
      check_output("rc_c2_req_valid", 32'(imem_req_valid), 32'd0);
      next_cycle();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("rc_c3_addr", imem_req_addr, 32'h5000);
      check_output("rc_c3_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("rc_c4_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("rc_c5_inst_valid", 32'(inst_valid), 32'd1);
      check_output("rc_c5_inst_pc", inst_pc, 32'h5000);
      check_output("rc_c5_inst_out", inst_out, 32'h2400_1400);

      // Asynchronous reset with the ring partly full
      do_reset();
      mem_lat = 1;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
      next_cycle();
      next_cycle();
      check_output("ar_pre_inst_valid", 32'(inst_valid), 32'd1);
      #1;
      rst             = 1'b1;
      imem_resp_valid = 1'b0;
      pend_q.delete();
      #1;
      check_output("ar_req_valid", 32'(imem_req_valid), 32'd0);
      check_output("ar_inst_valid", 32'(inst_valid), 32'd0);
      check_output("ar_inst_out", inst_out, 32'h0);
      check_output("ar_inst_pc", inst_pc, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("ar_c0_addr", imem_req_addr, 32'h3000);
      check_output("ar_c0_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("ar_c1_inst_valid", 32'(inst_valid), 32'd0);
      next_cycle();
      check_output("ar_c2_inst_valid", 32'(inst_valid), 32'd1);
      check_output("ar_c2_inst_pc", inst_pc, 32'h3000);

      // Pointer wrap: 11 instructions with a randomly stalling decoder
      do_reset();
      mem_lat  = 1;
      exp_pc   = 32'h3000;
      popped   = 0;
      accepted = 0;
      for (int cyc = 0; cyc < 200 && popped < 11; cyc++) begin
         apply_stimulus(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'b1);
         if (inst_valid && inst_ready) begin
            check_output("wrap_inst_pc", inst_pc, 32'(exp_pc));
            check_output("wrap_inst_out", inst_out, mem_word(32'(exp_pc)));
            exp_pc += 4;
            popped++;
         end
         if (imem_req_valid && imem_req_ready) begin
            accepted++;
         end
         check_output("wrap_occupancy_le_depth", 32'((accepted - popped) <= 4), 32'd1);
         next_cycle();
      end
      check_output("wrap_popped", 32'(popped), 32'd11);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
